// File: rtl/truth_table_sweeper.sv
// Exhaustive-sweep self-check engine: walks vec through every input code, samples z_in
// after a programmable settle time, builds the truth table and counts mismatches against expected.
module truth_table_sweeper #(
    parameter int NUM_IN        = 3,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [(1<<NUM_IN)-1:0]   expected,
    output logic [NUM_IN-1:0]        vec,
    input  logic                     z_in,
    output logic                     busy,
    output logic                     done,
    output logic [(1<<NUM_IN)-1:0]   table_out,
    output logic [NUM_IN:0]          mismatch_count,
    output logic                     match
);
    localparam int W  = 1 << NUM_IN;
    localparam int CW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state_q;
    logic [NUM_IN-1:0]     idx_q;
    logic [CW-1:0]         cnt_q;
    logic [W-1:0]          exp_q;
    logic [W-1:0]          table_q;
    logic [NUM_IN:0]       mcount_q;
    logic [NUM_IN-1:0]     vec_q;
    logic                  busy_q;
    logic                  done_q;

    logic sample_now;
    logic last_vec;

    assign sample_now = (cnt_q == CW'(SETTLE_CYCLES));
    assign last_vec   = (idx_q == NUM_IN'(W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            exp_q    <= '0;
            table_q  <= '0;
            mcount_q <= '0;
            vec_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    // A restart from DONE behaves exactly like a start from IDLE.
                    if (start) begin
                        state_q  <= RUN;
                        exp_q    <= expected;
                        table_q  <= '0;
                        mcount_q <= '0;
                        idx_q    <= '0;
                        cnt_q    <= '0;
                        vec_q    <= '0;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                    end
                end
                RUN: begin
                    if (sample_now) begin
                        table_q[idx_q] <= z_in;
                        if (z_in != exp_q[idx_q]) begin
                            mcount_q <= mcount_q + (NUM_IN+1)'(1);
                        end
                        cnt_q <= '0;
                        if (last_vec) begin
                            state_q <= DONE;
                            idx_q   <= '0;
                            vec_q   <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q <= idx_q + NUM_IN'(1);
                            vec_q <= idx_q + NUM_IN'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    vec_q   <= '0;
                end
            endcase
        end
    end

    assign vec            = vec_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign table_out      = table_q;
    assign mismatch_count = mcount_q;
    assign match          = done_q && (mcount_q == '0);

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: cycle model derived from sweep arithmetic (N=3,S=2)
// plus directed literal checks, and a second N=2,S=0 instance with an OR2 load.
module tb_truth_table_sweeper;
    localparam int S   = 2;
    localparam int TOT = 8 * (S + 1);

    logic       clk;
    logic       rst_n;
    logic       start_a;
    logic [7:0] exp_a;
    logic [2:0] vec_a;
    logic       z_a;
    logic       busy_a;
    logic       done_a;
    logic [7:0] table_a;
    logic [3:0] mc_a;
    logic       match_a;
    logic       fsel;

    logic       start_b;
    logic [3:0] exp_b;
    logic [1:0] vec_b;
    logic       z_b;
    logic       busy_b;
    logic       done_b;
    logic [3:0] table_b;
    logic [2:0] mc_b;
    logic       match_b;

    int checks;
    int failures;

    // Combinational loads: AND3 (fsel=0) or XOR3 (fsel=1); OR2 on the small instance.
    assign z_a = fsel ? (^vec_a) : (&vec_a);
    assign z_b = |vec_b;

    truth_table_sweeper #(.NUM_IN(3), .SETTLE_CYCLES(S)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .expected(exp_a), .vec(vec_a),
        .z_in(z_a), .busy(busy_a), .done(done_a), .table_out(table_a),
        .mismatch_count(mc_a), .match(match_a)
    );

    truth_table_sweeper #(.NUM_IN(2), .SETTLE_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .expected(exp_b), .vec(vec_b),
        .z_in(z_b), .busy(busy_b), .done(done_b), .table_out(table_b),
        .mismatch_count(mc_b), .match(match_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic logic [7:0] ftab(input logic sel);
        logic [7:0] t;
        t = '0;
        for (int i = 0; i < 8; i++) begin
            if (sel) t[i] = ($countones(i) % 2) == 1;
            else     t[i] = (i == 7);
        end
        return t;
    endfunction

    // Model: mode 0 idle, 1 sweeping (k = edges since start edge), 2 done.
    int         m_mode;
    int         m_k;
    logic [7:0] m_exp;
    logic       m_fsel;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode <= 0;
            m_k    <= 0;
            m_exp  <= '0;
            m_fsel <= 1'b0;
        end else if (m_mode != 1 && start_a) begin
            m_mode <= 1;
            m_k    <= 0;
            m_exp  <= exp_a;
            m_fsel <= fsel;
        end else if (m_mode == 1) begin
            if (m_k + 1 == TOT) m_mode <= 2;
            m_k <= m_k + 1;
        end
    end

    always @(negedge clk) begin
        int         samp;
        logic [7:0] msk;
        logic [7:0] tab;
        logic [2:0] e_vec;
        logic       e_busy;
        logic       e_done;
        int         e_mc;
        samp   = 0;
        e_vec  = '0;
        e_busy = 1'b0;
        e_done = 1'b0;
        if (rst_n && m_mode == 1) begin
            samp   = m_k / (S + 1);
            e_vec  = 3'(samp);
            e_busy = 1'b1;
        end else if (rst_n && m_mode == 2) begin
            samp   = 8;
            e_done = 1'b1;
        end
        msk  = (samp >= 8) ? 8'hFF : 8'((1 << samp) - 1);
        tab  = ftab(m_fsel) & msk;
        e_mc = $countones((tab ^ m_exp) & msk);
        chk("model_vec", 32'(vec_a), 32'(e_vec));
        chk("model_busy", 32'(busy_a), 32'(e_busy));
        chk("model_done", 32'(done_a), 32'(e_done));
        chk("model_table", 32'(table_a), 32'(tab));
        chk("model_mcount", 32'(mc_a), 32'(e_mc));
        chk("model_match", 32'(match_a), 32'(e_done && e_mc == 0));
    end

    task automatic pulse_start_a();
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;   // now at k=0
    endtask

    initial begin
        int cnt;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        start_a  = 1'b0;
        start_b  = 1'b0;
        exp_a    = 8'h80;
        exp_b    = 4'b1110;
        fsel     = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_done", 32'(done_a), 0);
        chk("rst_table", 32'(table_a), 0);
        chk("rst_match", 32'(match_a), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // AND3 sweep; also exact completion edge
        pulse_start_a();
        exp_a = 8'h00;  // must be ignored, captured at start
        repeat (23) @(negedge clk);
        chk("and3_done_early", 32'(done_a), 0);
        @(negedge clk);
        chk("and3_done", 32'(done_a), 1);
        chk("and3_table", 32'(table_a), 32'h80);
        chk("and3_mcount", 32'(mc_a), 0);
        chk("and3_match", 32'(match_a), 1);
        $display("sweep AND3 table=%02h mismatches=%0d", table_a, mc_a);

        // XOR3 against 8'h97, busy counted over the sweep
        fsel  = 1'b1;
        exp_a = 8'h97;
        @(negedge clk) start_a = 1'b1;
        cnt = 0;
        repeat (30) begin
            @(negedge clk) start_a = 1'b0;
            if (busy_a) cnt++;
        end
        chk("xor3_busy_cycles", 32'(cnt), 24);
        chk("xor3_table", 32'(table_a), 32'h96);
        chk("xor3_mcount", 32'(mc_a), 1);
        chk("xor3_match", 32'(match_a), 0);
        $display("sweep XOR3 table=%02h mismatches=%0d", table_a, mc_a);

        // start at cycle 10 ignored, completion still at E0+24
        pulse_start_a();
        repeat (9) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        repeat (13) @(negedge clk);
        chk("ign_done_early", 32'(done_a), 0);
        @(negedge clk);
        chk("ign_done", 32'(done_a), 1);
        $display("sweep with ignored start table=%02h", table_a);

        // restart from DONE clears results
        pulse_start_a();
        chk("restart_table_clr", 32'(table_a), 0);
        chk("restart_mc_clr", 32'(mc_a), 0);
        repeat (24) @(negedge clk);
        chk("restart_done", 32'(done_a), 1);
        $display("restart sweep table=%02h mismatches=%0d", table_a, mc_a);

        // async reset mid-sweep
        pulse_start_a();
        repeat (11) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy_a), 0);
        chk("arst_vec", 32'(vec_a), 0);
        chk("arst_table", 32'(table_a), 0);
        chk("arst_mcount", 32'(mc_a), 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("arst_idle_busy", 32'(busy_a), 0);
        chk("arst_idle_done", 32'(done_a), 0);
        $display("reset mid-sweep, stayed idle busy=%0d", busy_a);

        // start held high through sweep and into DONE
        @(negedge clk) start_a = 1'b1;
        cnt = 0;
        repeat (27) begin
            @(negedge clk);
            if (done_a) cnt++;
        end
        start_a = 1'b0;
        chk("held_done_pulse", 32'(cnt), 1);
        repeat (30) @(negedge clk);
        $display("held-start sweeps done, done=%0d", done_a);

        // N=2, S=0, OR2
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("b_vec", 32'(vec_b), 32'(k));
            chk("b_busy", 32'(busy_b), 1);
            @(negedge clk);
        end
        chk("b_done", 32'(done_b), 1);
        chk("b_vec_done", 32'(vec_b), 0);
        chk("b_table", 32'(table_b), 32'hE);
        chk("b_mcount", 32'(mc_b), 0);
        chk("b_match", 32'(match_b), 1);
        $display("sweep OR2 table=%01h mismatches=%0d", table_b, mc_b);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
